// File: rtl/fpu_wb_scheduler_if.sv
// rtl/fpu_wb_scheduler_if.sv - FP register-file writeback port bundle (pipeline, divider, decode, scoreboard).
interface fpu_wb_scheduler_if #(
  parameter int FLEN = 64
);
  logic            PipeWe;
  logic [4:0]      PipeAdr;
  logic [FLEN-1:0] PipeData;
  logic            DivValid;
  logic [4:0]      DivAdr;
  logic [FLEN-1:0] DivData;
  logic            DivReady;
  logic            DivIssue;
  logic [4:0]      DivIssueAdr;
  logic [2:0]      RdEn;
  logic [4:0]      Ra1;
  logic [4:0]      Ra2;
  logic [4:0]      Ra3;
  logic            DestEn;
  logic [4:0]      DestAdr;
  logic            we4;
  logic [4:0]      a4;
  logic [FLEN-1:0] wd4;
  logic            HazardStall;
  logic            StallPipe;
  logic [31:0]     Pending;

  modport slave (
    input  PipeWe, PipeAdr, PipeData,
    input  DivValid, DivAdr, DivData,
    output DivReady,
    input  DivIssue, DivIssueAdr,
    input  RdEn, Ra1, Ra2, Ra3, DestEn, DestAdr,
    output we4, a4, wd4,
    output HazardStall, StallPipe, Pending
  );

  modport master (
    output PipeWe, PipeAdr, PipeData,
    output DivValid, DivAdr, DivData,
    input  DivReady,
    output DivIssue, DivIssueAdr,
    output RdEn, Ra1, Ra2, Ra3, DestEn, DestAdr,
    input  we4, a4, wd4,
    input  HazardStall, StallPipe, Pending
  );
endinterface

// File: rtl/fpu_wb_scheduler.sv
// rtl/fpu_wb_scheduler.sv - shares one FP regfile write port between W stage and divsqrt,
// tracks outstanding divider writes and forces pipeline bubbles when the divider starves.
module fpu_wb_scheduler #(
  parameter int FLEN    = 64,
  parameter int MAXWAIT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  fpu_wb_scheduler_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MAXWAIT - 1);

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0] pending_q, pending_d;
  logic        stall_pipe_q, stall_pipe_d;

  logic        div_ready;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic        hazard;

  // The W stage cannot stall, so it always owns the port when it writes.
  assign div_ready    = bus.DivValid & ~bus.PipeWe;
  assign bus.DivReady = div_ready;
  assign bus.we4      = bus.PipeWe | bus.DivValid;
  assign bus.a4       = bus.PipeWe ? bus.PipeAdr  : (bus.DivValid ? bus.DivAdr  : 5'd0);
  assign bus.wd4      = bus.PipeWe ? bus.PipeData : (bus.DivValid ? bus.DivData : {FLEN{1'b0}});

  always_comb begin
    set_mask  = 32'd0;
    clr_mask  = 32'd0;
    if (bus.DivIssue) begin
      set_mask = 32'd1 << bus.DivIssueAdr;
    end
    if (div_ready) begin
      clr_mask = 32'd1 << bus.DivAdr;
    end
    // A re-issue to the register being retired keeps the bit set.
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  always_comb begin
    hazard = (bus.RdEn[0] & pending_q[bus.Ra1])
           | (bus.RdEn[1] & pending_q[bus.Ra2])
           | (bus.RdEn[2] & pending_q[bus.Ra3])
           | (bus.DestEn  & pending_q[bus.DestAdr]);
  end

  assign bus.HazardStall = hazard & ~reset;
  assign bus.Pending     = pending_q;
  assign bus.StallPipe   = stall_pipe_q;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.DivValid && !div_ready) begin
          state_d    = S_WAIT;
          wait_cnt_d = 4'd1;
        end else begin
          wait_cnt_d = 4'd0;
        end
      end
      S_WAIT: begin
        if (!bus.DivValid || div_ready) begin
          state_d    = S_IDLE;
          wait_cnt_d = 4'd0;
        end else if (wait_cnt_q >= WAIT_LAST) begin
          state_d = S_FORCE;
        end else begin
          wait_cnt_d = wait_cnt_q + 4'd1;
        end
      end
      S_FORCE: begin
        // Leaving on a dropped request too avoids stalling the pipe forever.
        if (!bus.DivValid || div_ready) begin
          state_d    = S_IDLE;
          wait_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d    = S_IDLE;
        wait_cnt_d = 4'd0;
      end
    endcase
    stall_pipe_d = (state_d == S_FORCE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= 4'd0;
      pending_q    <= 32'd0;
      stall_pipe_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      pending_q    <= pending_d;
      stall_pipe_q <= stall_pipe_d;
    end
  end

endmodule

// File: tb/tb_fpu_wb_scheduler.sv
// tb/tb_fpu_wb_scheduler.sv - scoreboard bench for fpu_wb_scheduler writeback arbitration.
module tb_fpu_wb_scheduler;

  typedef struct {
    logic [4:0]  adr;
    logic [63:0] data;
  } wr_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  wr_t  exp_q[$];

  fpu_wb_scheduler_if #(.FLEN(64)) ifc ();

  fpu_wb_scheduler #(.FLEN(64), .MAXWAIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ifc.PipeWe = 0; ifc.PipeAdr = 0; ifc.PipeData = 0;
    ifc.DivValid = 0; ifc.DivAdr = 0; ifc.DivData = 0;
    ifc.DivIssue = 0; ifc.DivIssueAdr = 0;
    ifc.RdEn = 0; ifc.Ra1 = 0; ifc.Ra2 = 0; ifc.Ra3 = 0;
    ifc.DestEn = 0; ifc.DestAdr = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [4:0] adr, input logic [63:0] data);
    wr_t w;
    w.adr  = adr;
    w.data = data;
    exp_q.push_back(w);
  endtask

  // Monitor: every port write outside reset must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset) begin
      if (ifc.we4) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_adr", {59'd0, ifc.a4}, 64'hFFFF);
        end else begin
          wr_t w;
          w = exp_q.pop_front();
          chk("wr_adr", {59'd0, ifc.a4}, {59'd0, w.adr});
          chk("wr_data", ifc.wd4, w.data);
        end
      end
      if (ifc.PipeWe && ifc.Pending[ifc.PipeAdr]) begin
        fails++;
        $display("FAIL pipe_write_to_pending: adr %0d pending %0h", ifc.PipeAdr, ifc.Pending);
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    idle_inputs();
    reset = 1'b1;

    // Reset: state cleared, port mux still combinational, no hazard.
    ifc.DivValid = 1; ifc.DivAdr = 5'd12; ifc.DivData = 64'hAB;
    ifc.RdEn = 3'b111; ifc.DestEn = 1;
    @(negedge clk);
    chk("rst_pending", ifc.Pending, 64'd0);
    chk("rst_stall", ifc.StallPipe, 0);
    chk("rst_hazard", ifc.HazardStall, 0);
    chk("rst_divready", ifc.DivReady, 1);
    chk("rst_a4", ifc.a4, 12);
    idle_inputs();
    next_cycle();
    reset = 1'b0;
    next_cycle();

    // Issue f5, read it back (hazard), then uncontended retire.
    ifc.DivIssue = 1; ifc.DivIssueAdr = 5'd5;
    next_cycle();
    idle_inputs();
    ifc.RdEn = 3'b001; ifc.Ra1 = 5'd5;
    @(negedge clk);
    chk("raw_hazard", ifc.HazardStall, 1);
    chk("pending_f5", ifc.Pending, 64'h20);
    next_cycle();
    ifc.DivValid = 1; ifc.DivAdr = 5'd5; ifc.DivData = 64'h1111_2222_3333_4444;
    push_wr(5'd5, 64'h1111_2222_3333_4444);
    @(negedge clk);
    chk("div_ready_free", ifc.DivReady, 1);
    next_cycle();
    ifc.DivValid = 0;
    @(negedge clk);
    chk("pending_cleared", ifc.Pending, 0);
    chk("hazard_cleared", ifc.HazardStall, 0);
    ifc.RdEn = 0; ifc.DestEn = 1; ifc.DestAdr = 5'd5;
    #1;
    chk("waw_no_hazard", ifc.HazardStall, 0);
    next_cycle();
    idle_inputs();

    // Pipe and divider collide: pipe first, divider next cycle.
    ifc.PipeWe = 1; ifc.PipeAdr = 5'd3; ifc.PipeData = 64'hCAFE;
    ifc.DivValid = 1; ifc.DivAdr = 5'd7; ifc.DivData = 64'hBEEF;
    push_wr(5'd3, 64'hCAFE);
    @(negedge clk);
    chk("collide_divready", ifc.DivReady, 0);
    next_cycle();
    ifc.PipeWe = 0;
    push_wr(5'd7, 64'hBEEF);
    @(negedge clk);
    chk("collide_second_ready", ifc.DivReady, 1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("collide_no_stall", ifc.StallPipe, 0);
    next_cycle();

    // Starvation: four denied cycles then forced bubbles.
    ifc.DivIssue = 1; ifc.DivIssueAdr = 5'd8;
    next_cycle();
    ifc.DivIssue = 0;
    ifc.DivValid = 1; ifc.DivAdr = 5'd8; ifc.DivData = 64'h8888;
    for (int i = 0; i < 5; i++) begin
      ifc.PipeWe = 1; ifc.PipeAdr = 5'(16 + i); ifc.PipeData = 64'(i + 100);
      push_wr(5'(16 + i), 64'(i + 100));
      @(negedge clk);
      chk($sformatf("starve_stall_c%0d", i + 1), ifc.StallPipe, (i == 4) ? 1 : 0);
      chk($sformatf("starve_ready_c%0d", i + 1), ifc.DivReady, 0);
      next_cycle();
    end
    ifc.PipeWe = 0;
    push_wr(5'd8, 64'h8888);
    @(negedge clk);
    chk("force_ready", ifc.DivReady, 1);
    chk("force_stall_hold", ifc.StallPipe, 1);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("force_release", ifc.StallPipe, 0);
    chk("force_pending", ifc.Pending, 0);
    next_cycle();

    // Re-issue to f9 while f9 retires: bit must stay set.
    ifc.DivIssue = 1; ifc.DivIssueAdr = 5'd9;
    next_cycle();
    ifc.DivValid = 1; ifc.DivAdr = 5'd9; ifc.DivData = 64'h9999;
    push_wr(5'd9, 64'h9999);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("set_wins", ifc.Pending, 64'h200);
    next_cycle();
    ifc.DivValid = 1; ifc.DivAdr = 5'd9; ifc.DivData = 64'h9A9A;
    push_wr(5'd9, 64'h9A9A);
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("f9_cleared", ifc.Pending, 0);
    next_cycle();

    // Reset asserted while in FORCE with f8 pending.
    ifc.DivIssue = 1; ifc.DivIssueAdr = 5'd8;
    next_cycle();
    ifc.DivIssue = 0;
    ifc.DivValid = 1; ifc.DivAdr = 5'd8; ifc.DivData = 64'h8080;
    for (int i = 0; i < 5; i++) begin
      ifc.PipeWe = 1; ifc.PipeAdr = 5'(20 + i); ifc.PipeData = 64'(i + 200);
      push_wr(5'(20 + i), 64'(i + 200));
      if (i < 4) next_cycle();
    end
    @(negedge clk);
    chk("pre_rst_stall", ifc.StallPipe, 1);
    chk("pre_rst_pending", ifc.Pending, 64'h100);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_stall", ifc.StallPipe, 0);
    chk("async_rst_pending", ifc.Pending, 0);
    idle_inputs();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", ifc.StallPipe, 0);
    chk("post_rst_we4", ifc.we4, 0);
    next_cycle();
    next_cycle();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_wb_scheduler.md
FPU_WB_SCHEDULER -- requirements
Module: fpu_wb_scheduler

Interface
REQ-001 Parameter FLEN, default 64, width of FP register data.
REQ-002 Parameter MAXWAIT, default 4, max cycles a divider result may be denied before the pipeline is forced to yield; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 PipeWe, PipeAdr, PipeData  input  1/5/FLEN  FP pipeline writeback request (W stage), not stallable.
REQ-006 DivValid, DivAdr, DivData  input  1/5/FLEN  divsqrt result request; held stable until accepted.
REQ-007 DivReady  output  1  divider result accepted this cycle.
REQ-008 DivIssue, DivIssueAdr  input  1/5  divsqrt op issued this cycle with destination register.
REQ-009 RdEn, Ra1, Ra2, Ra3  input  3/5/5/5  source operands of the instruction in decode (RdEn[i] enables Ra(i+1)).
REQ-010 DestEn, DestAdr  input  1/5  FP destination of the instruction in decode.
REQ-011 we4, a4, wd4  output  1/5/FLEN  register-file write port drive.
REQ-012 HazardStall  output  1  decode must stall (RAW/WAW on pending divider destination).
REQ-013 StallPipe  output  1  registered; pipeline must insert W-stage bubbles while high.
REQ-014 Pending  output  32  scoreboard, bit n = divider write to f[n] outstanding.

Function
REQ-015 Write-port mux combinational: PipeWe=1 -> we4=1, a4=PipeAdr, wd4=PipeData; else DivValid=1 -> we4=1, a4=DivAdr, wd4=DivData; else we4=0, a4=0, wd4=0.
REQ-016 DivReady = DivValid & ~PipeWe (pipeline has fixed priority on the single port).
REQ-017 Pending[DivIssueAdr] set at posedge when DivIssue=1.
REQ-018 Pending[DivAdr] cleared at posedge when DivValid & DivReady.
REQ-019 Set and clear of same bit in same cycle: set wins (bit stays 1).
REQ-020 HazardStall = (RdEn[0]&Pending[Ra1]) | (RdEn[1]&Pending[Ra2]) | (RdEn[2]&Pending[Ra3]) | (DestEn&Pending[DestAdr]), combinational from registered Pending.
REQ-021 FSM states IDLE, WAIT, FORCE; 4-bit WaitCnt.
REQ-022 IDLE: DivValid & ~DivReady -> WAIT, WaitCnt<=1; otherwise stay, WaitCnt=0.
REQ-023 WAIT: DivReady -> IDLE, WaitCnt<=0; DivValid & ~DivReady & WaitCnt==MAXWAIT-1 -> FORCE; else WaitCnt<=WaitCnt+1.
REQ-024 WAIT with DivValid dropped (protocol violation) -> IDLE, WaitCnt<=0.
REQ-025 FORCE: StallPipe=1; DivReady -> IDLE next cycle (StallPipe low next cycle); otherwise stay.
REQ-026 StallPipe is a registered decode of state==FORCE; PipeWe still wins the port in FORCE if asserted (in-flight W op), with no loss of either write.
REQ-027 Latency: uncontended divider result written same cycle DivValid rises; Pending bit clears at following posedge.
REQ-028 PipeWe to register with Pending bit set is not blocked here (HazardStall upstream prevents it); bench flags it as assertion failure.

Reset
REQ-029 reset=1 asynchronously forces state=IDLE, WaitCnt=0, Pending=0, StallPipe=0.
REQ-030 During reset, outputs we4/a4/wd4/DivReady follow REQ-015/016 combinationally; HazardStall=0.
REQ-031 Reset mid-FORCE or mid-WAIT drops StallPipe immediately; no write replayed after reset release.

Verification
REQ-032 DivIssue f5; next cycle RdEn=001, Ra1=5 -> HazardStall=1; DivValid DivAdr=5 PipeWe=0 -> we4=1 a4=5, DivReady=1, Pending[5]=0 and HazardStall=0 next cycle.
REQ-033 PipeWe=1 a4=3 and DivValid a4=7 same cycle -> we4 a4=3, DivReady=0; next cycle PipeWe=0 -> a4=7, DivReady=1.
REQ-034 MAXWAIT=4, DivValid held, PipeWe=1 every cycle -> StallPipe rises after 4 denied cycles; PipeWe dropped -> DivReady=1, StallPipe=0 the cycle after.
REQ-035 DivIssue f9 in same cycle as divider retire to f9 -> Pending[9] remains 1.
REQ-036 reset asserted in FORCE with Pending=0x0000_0100 -> StallPipe=0, Pending=0 without clock edge.
